// File: rtl/lif_sched_pkg.sv
// Shared types and constants for the LIF neuron scheduler.
package lif_sched_pkg;

    localparam int unsigned STATE_W    = 16;
    localparam int unsigned BETA_SHIFT = 8;
    localparam int unsigned PROD_W     = 2 * STATE_W;

    localparam logic [STATE_W-1:0] THRESH_RST = 16'd100;
    localparam logic [STATE_W-1:0] BETA_RST   = 16'd224;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        UPDATE = 3'd2,
        EMIT   = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } sched_state_e;

    // Shared neuron configuration, constant across a timestep.
    typedef struct packed {
        logic [STATE_W-1:0] threshold;
        logic [STATE_W-1:0] beta;
    } lif_cfg_t;

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF step: spike test on the old state, otherwise leak and integrate.
module lif_update_core
    import lif_sched_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [STATE_W-1:0] current_i,
    input  logic [STATE_W-1:0] threshold_i,
    input  logic [STATE_W-1:0] beta_i,
    output logic [STATE_W-1:0] next_state_c_o,
    output logic               spike_c_o
);

    logic [PROD_W-1:0]  prod_c;
    logic [STATE_W-1:0] decay_c;

    // Q8 decay with truncation, modulo-2^16 accumulate, reset-to-zero on spike.
    always_comb begin
        prod_c         = PROD_W'(state_i) * PROD_W'(beta_i);
        decay_c        = STATE_W'(prod_c >> BETA_SHIFT);
        spike_c_o      = (state_i >= threshold_i);
        next_state_c_o = spike_c_o ? '0 : STATE_W'(current_i + decay_c);
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: one update datapath shared by N_NEURONS
// virtual neurons, fed by a current stream and emitting a spike-index stream.
// Optional refractory counters are enabled by defining LIF_SCHED_REFRACT_EN.
module lif_scheduler
    import lif_sched_pkg::*;
#(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned IDX_W     = 2
`ifdef LIF_SCHED_REFRACT_EN
   ,parameter int unsigned REFRACT_STEPS = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cfg_we,
    input  logic [15:0]        cfg_threshold,
    input  logic [15:0]        cfg_beta,
    input  logic               cur_valid,
    output logic               cur_ready,
    input  logic [15:0]        cur_data,
    output logic [IDX_W-1:0]   cur_idx,
    output logic               spk_valid,
    input  logic               spk_ready,
    output logic [IDX_W-1:0]   spk_idx,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [15:0]        rd_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    sched_state_e       fsm_q, fsm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    lif_cfg_t           cfg_q, cfg_d;
    logic [STATE_W-1:0] mem_q [N_NEURONS];

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cur_ready_q, cur_ready_d;
    logic               spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0]   spk_idx_q, spk_idx_d;
    logic [IDX_W-1:0]   cur_idx_q;

    logic [STATE_W-1:0] core_next_c;
    logic               core_spike_c;
    logic [STATE_W-1:0] upd_next_c;
    logic               upd_spike_c;

    lif_update_core u_core (
        .state_i        (mem_q[idx_q]),
        .current_i      (cur_q),
        .threshold_i    (cfg_q.threshold),
        .beta_i         (cfg_q.beta),
        .next_state_c_o (core_next_c),
        .spike_c_o      (core_spike_c)
    );

`ifdef LIF_SCHED_REFRACT_EN
    localparam int unsigned REF_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

    logic [REF_W-1:0] ref_q [N_NEURONS];
    logic             ref_active_c;

    // A refractory neuron swallows its current, stays at zero and cannot fire.
    always_comb begin
        ref_active_c = (ref_q[idx_q] != '0);
        upd_spike_c  = core_spike_c & ~ref_active_c;
        upd_next_c   = ref_active_c ? '0 : core_next_c;
    end

    // Refractory counters: load on spike, count down once per visited timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                ref_q[i] <= '0;
            end
        end else if (fsm_q == UPDATE) begin
            if (ref_active_c) begin
                ref_q[idx_q] <= ref_q[idx_q] - REF_W'(1);
            end else if (core_spike_c) begin
                ref_q[idx_q] <= REF_W'(REFRACT_STEPS);
            end
        end
    end
`else
    // Without refractory support the core result is used unchanged.
    always_comb begin
        upd_spike_c = core_spike_c;
        upd_next_c  = core_next_c;
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        cfg_d     = cfg_q;
        spk_idx_d = spk_idx_q;

        unique case (fsm_q)
            IDLE: begin
                if (cfg_we) begin
                    cfg_d.threshold = cfg_threshold;
                    cfg_d.beta      = cfg_beta;
                end
                if (start) begin
                    fsm_d = LOAD;
                end
            end
            LOAD: begin
                if (cur_valid && cur_ready_q) begin
                    cur_d = cur_data;
                    fsm_d = UPDATE;
                end
            end
            UPDATE: begin
                if (upd_spike_c) begin
                    spk_idx_d = idx_q;
                    fsm_d     = EMIT;
                end else begin
                    fsm_d = NEXT;
                end
            end
            EMIT: begin
                if (spk_valid_q && spk_ready) begin
                    fsm_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    fsm_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    fsm_d = LOAD;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        busy_d      = (fsm_d != IDLE);
        done_d      = (fsm_d == DONE);
        cur_ready_d = (fsm_d == LOAD);
        spk_valid_d = (fsm_d == EMIT);
    end

    // Control, configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            idx_q       <= '0;
            cur_q       <= '0;
            cfg_q       <= '{threshold: THRESH_RST, beta: BETA_RST};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cur_ready_q <= 1'b0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            cur_idx_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            cfg_q       <= cfg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cur_ready_q <= cur_ready_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            cur_idx_q   <= idx_d;
        end
    end

    // Per-neuron membrane state, written once per neuron in UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (fsm_q == UPDATE) begin
            mem_q[idx_q] <= upd_next_c;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_ready = cur_ready_q;
    assign spk_valid = spk_valid_q;
    assign spk_idx   = spk_idx_q;
    assign cur_idx   = cur_idx_q;
    assign rd_state  = mem_q[rd_idx];

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed self-checking bench for lif_scheduler (N_NEURONS=4).
module tb_lif_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        cfg_we;
    logic [15:0] cfg_threshold;
    logic [15:0] cfg_beta;
    logic        cur_valid;
    logic        cur_ready;
    logic [15:0] cur_data;
    logic [1:0]  cur_idx;
    logic        spk_valid;
    logic        spk_ready;
    logic [1:0]  spk_idx;
    logic [1:0]  rd_idx;
    logic [15:0] rd_state;

    int vectors;
    int miscompares;
    logic [15:0] cur_vec [4];
    int spk_log [$];

    lif_scheduler #(.N_NEURONS(4), .IDX_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .cfg_we        (cfg_we),
        .cfg_threshold (cfg_threshold),
        .cfg_beta      (cfg_beta),
        .cur_valid     (cur_valid),
        .cur_ready     (cur_ready),
        .cur_data      (cur_data),
        .cur_idx       (cur_idx),
        .spk_valid     (spk_valid),
        .spk_ready     (spk_ready),
        .spk_idx       (spk_idx),
        .rd_idx        (rd_idx),
        .rd_state      (rd_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [15:0] thr, input logic [15:0] beta);
        cfg_we        = 1'b1;
        cfg_threshold = thr;
        cfg_beta      = beta;
        tick();
        cfg_we        = 1'b0;
    endtask

    task automatic read_state(input int i, output logic [15:0] v);
        rd_idx = 2'(i);
        #1;
        v = rd_state;
    endtask

    // Feed cur_vec, accept every spike, log spikes and count done cycles until idle.
    task automatic drain(output int dones);
        int cyc;
        dones = 0;
        cyc   = 0;
        while (busy && cyc < 300) begin
            cur_valid = cur_ready;
            cur_data  = cur_vec[cur_idx];
            spk_ready = 1'b1;
            if (spk_valid) spk_log.push_back(int'(spk_idx));
            if (done) dones++;
            tick();
            cyc++;
        end
        cur_valid = 1'b0;
        spk_ready = 1'b0;
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic run_step(output int dones);
        spk_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(dones);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1;
        #3;
        vectors++;
        if ({busy, done, cur_ready, spk_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/cur_ready/spk_valid=%b, required 0000",
                     {busy, done, cur_ready, spk_valid});
        end
        vectors++;
        if (spk_idx !== 2'd0 || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idx: spk_idx=%0d cur_idx=%0d, required 0/0", spk_idx, cur_idx);
        end
        for (int i = 0; i < 4; i++) begin
            read_state(i, v);
            vectors++;
            if (v !== 16'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %0d, required 0", i, v);
            end
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int dones;
        logic [15:0] v;
        logic [15:0] exp_state [4];
        exp_state = '{16'd50, 16'd93, 16'd131, 16'd0};
        do_reset();
        cur_vec = '{16'd50, 16'd50, 16'd50, 16'd50};
        for (int t = 0; t < 4; t++) begin
            run_step(dones);
            vectors++;
            if (dones !== 1) begin
                miscompares++;
                $display("FAIL basic_done t%0d: %0d done cycles, required 1", t, dones);
            end
            for (int i = 0; i < 4; i++) begin
                read_state(i, v);
                vectors++;
                if (v !== exp_state[t]) begin
                    miscompares++;
                    $display("FAIL basic_state t%0d n%0d: got %0d, required %0d", t, i, v, exp_state[t]);
                end
            end
            vectors++;
            if (spk_log.size() !== ((t == 3) ? 4 : 0)) begin
                miscompares++;
                $display("FAIL basic_spike_count t%0d: got %0d, required %0d",
                         t, spk_log.size(), (t == 3) ? 4 : 0);
            end
        end
        if (spk_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (spk_log[i] !== i) begin
                    miscompares++;
                    $display("FAIL basic_spike_order %0d: got %0d, required %0d", i, spk_log[i], i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int dones;
        int cyc;
        logic [15:0] v;
        do_reset();
        cur_vec = '{16'd0, 16'd150, 16'd0, 16'd0};
        run_step(dones);
        cur_valid = 1'b1;
        cur_data  = 16'd0;
        spk_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!spk_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        vectors++;
        if (spk_valid !== 1'b1 || spk_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_first_spike: valid=%0b idx=%0d, required 1/1", spk_valid, spk_idx);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (spk_valid !== 1'b1 || spk_idx !== 2'd1 || cur_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: valid=%0b idx=%0d cur_ready=%0b, required 1/1/0",
                         k, spk_valid, spk_idx, cur_ready);
            end
        end
        spk_ready = 1'b1;
        tick();
        spk_ready = 1'b0;
        vectors++;
        if (spk_valid !== 1'b0 || busy !== 1'b1 || cur_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: valid=%0b busy=%0b cur_ready=%0b, required 0/1/0",
                     spk_valid, busy, cur_ready);
        end
        tick();
        vectors++;
        if (cur_ready !== 1'b1 || cur_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_resume: cur_ready=%0b cur_idx=%0d, required 1/2", cur_ready, cur_idx);
        end
        cur_vec = '{16'd0, 16'd0, 16'd0, 16'd0};
        drain(dones);
        read_state(1, v);
        vectors++;
        if (v !== 16'd0) begin
            miscompares++;
            $display("FAIL bp_state1: got %0d, required 0", v);
        end
    endtask

    task automatic test_wrap();
        int dones;
        logic [15:0] v;
        do_reset();
        cfg_write(16'hFFFF, 16'd224);
        cur_vec = '{16'h8000, 16'd0, 16'd0, 16'd0};
        run_step(dones);
        read_state(0, v);
        vectors++;
        if (v !== 16'h8000 || spk_log.size() !== 0) begin
            miscompares++;
            $display("FAIL wrap_step1: state=%h spikes=%0d, required 8000/0", v, spk_log.size());
        end
        cur_vec = '{16'hA000, 16'd0, 16'd0, 16'd0};
        run_step(dones);
        read_state(0, v);
        vectors++;
        if (v !== 16'h1000 || spk_log.size() !== 0) begin
            miscompares++;
            $display("FAIL wrap_step2: state=%h spikes=%0d, required 1000/0", v, spk_log.size());
        end
    endtask

    task automatic test_ignored_controls();
        int dones;
        int extra;
        logic [15:0] v;
        do_reset();
        cur_vec   = '{16'd50, 16'd50, 16'd50, 16'd50};
        cur_valid = 1'b0;
        start     = 1'b1;
        tick();
        start         = 1'b0;
        cfg_we        = 1'b1;
        cfg_threshold = 16'd10;
        cfg_beta      = 16'd224;
        start         = 1'b1;
        tick();
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        vectors++;
        if (cur_ready !== 1'b1 || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL ign_stall: cur_ready=%0b cur_idx=%0d, required 1/0", cur_ready, cur_idx);
        end
        spk_log.delete();
        drain(dones);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) extra++;
            tick();
        end
        vectors++;
        if (dones + extra !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_done: %0d done cycles busy=%0b, required 1/0", dones + extra, busy);
        end
        run_step(dones);
        read_state(2, v);
        vectors++;
        if (v !== 16'd93 || spk_log.size() !== 0) begin
            miscompares++;
            $display("FAIL ign_threshold_kept: state=%0d spikes=%0d, required 93/0", v, spk_log.size());
        end
        cfg_write(16'd10, 16'd224);
        run_step(dones);
        read_state(3, v);
        vectors++;
        if (v !== 16'd0 || spk_log.size() !== 4) begin
            miscompares++;
            $display("FAIL ign_cfg_later: state=%0d spikes=%0d, required 0/4", v, spk_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int cyc;
        logic [15:0] v;
        do_reset();
        cfg_write(16'd10, 16'd128);
        cur_vec = '{16'd50, 16'd50, 16'd50, 16'd50};
        run_step(dones);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!(cur_ready && cur_idx == 2'd2) && cyc < 100) begin
            cur_valid = cur_ready;
            cur_data  = 16'd50;
            spk_ready = 1'b1;
            tick();
            cyc++;
        end
        cur_valid = 1'b0;
        spk_ready = 1'b0;
        vectors++;
        if (cur_ready !== 1'b1 || cur_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL rmid_reach_load2: cur_ready=%0b cur_idx=%0d, required 1/2", cur_ready, cur_idx);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || cur_ready !== 1'b0 || spk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_ctrl: busy=%0b cur_ready=%0b spk_valid=%0b, required 0/0/0",
                     busy, cur_ready, spk_valid);
        end
        for (int i = 0; i < 4; i++) begin
            read_state(i, v);
            vectors++;
            if (v !== 16'd0) begin
                miscompares++;
                $display("FAIL rmid_state[%0d]: got %0d, required 0", i, v);
            end
        end
        tick();
        rst = 1'b0;
        tick();
        run_step(dones);
        run_step(dones);
        read_state(1, v);
        vectors++;
        if (v !== 16'd93 || spk_log.size() !== 0) begin
            miscompares++;
            $display("FAIL rmid_cfg_restored: state=%0d spikes=%0d, required 93/0", v, spk_log.size());
        end
    endtask

`ifdef LIF_SCHED_REFRACT_EN
    task automatic test_refract();
        int dones;
        logic [15:0] v;
        logic [15:0] exp_state [6];
        int          exp_spk [6];
        exp_state = '{16'd200, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0};
        exp_spk   = '{0, 1, 0, 0, 0, 1};
        do_reset();
        cur_vec = '{16'd200, 16'd0, 16'd0, 16'd0};
        for (int t = 0; t < 6; t++) begin
            run_step(dones);
            read_state(0, v);
            vectors++;
            if (v !== exp_state[t] || spk_log.size() !== exp_spk[t]) begin
                miscompares++;
                $display("FAIL refract t%0d: state=%0d spikes=%0d, required %0d/%0d",
                         t, v, spk_log.size(), exp_state[t], exp_spk[t]);
            end
        end
    endtask
`endif

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_we        = 1'b0;
        cfg_threshold = 16'd0;
        cfg_beta      = 16'd0;
        cur_valid     = 1'b0;
        cur_data      = 16'd0;
        spk_ready     = 1'b0;
        rd_idx        = 2'd0;
        cur_vec       = '{16'd0, 16'd0, 16'd0, 16'd0};

        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ignored_controls();
        test_reset_mid();
`ifdef LIF_SCHED_REFRACT_EN
        test_refract();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
